// File: rtl/pattern_detect_p.sv
// Serial pattern detector: a programmable PAT_W-bit pattern with optional overlap,
// a registered match pulse and a saturating match counter.
module pattern_detect_p #(
   parameter int                   PAT_W   = 4,
   parameter int                   CNT_W   = 8,
   parameter logic [PAT_W-1:0]     RST_PAT = PAT_W'(4'b1101)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_data,
   input  logic             clr_count,
   output logic             out,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat,
   output logic [PAT_W-1:0] pat_q
);

   localparam int                FILL_W   = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PAT_W-1:0]  pat_d;
   logic              out_q;
   logic              match;

   // A load cycle throws away the incoming bit, so it can never complete a match.
   always_comb begin
      match = in_valid && !pat_load && (fill_q >= FILL_THR) &&
              ({hist_q[PAT_W-2:0], in} == pat_q);
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      pat_d  = pat_q;
      if (pat_load) begin
         pat_d  = pat_data;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = {hist_q[PAT_W-2:0], in};
         if (match)
            fill_d = overlap ? fill_q : '0;
         else if (fill_q != FILL_MAX)
            fill_d = fill_q + FILL_W'(1);
      end
      if (clr_count)
         cnt_d = match ? CNT_W'(1) : '0;
      else if (match && !count_sat)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         pat_q  <= RST_PAT;
         out_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         pat_q  <= pat_d;
         out_q  <= match;
      end
   end

   assign out         = out_q;
   assign match_count = cnt_q;
   assign count_sat   = &cnt_q;

endmodule

// File: doc/pattern_detect_p.md
PATTERN_DETECT_P -- requirements
Module: pattern_detect_p

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, match counter width, legal range 1..16.
REQ-003 SHALL have parameter RST_PAT, default 4'b1101 (PAT_W bits), pattern loaded at reset.
REQ-004 SHALL have a single clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in  input  1  serial data bit.
REQ-008 in_valid  input  1  qualifies in; a bit is consumed only when in_valid=1.
REQ-009 overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-010 pat_load  input  1  load pat_data as the new pattern.
REQ-011 pat_data  input  PAT_W  new pattern; MSB is the first-arriving bit.
REQ-012 clr_count  input  1  clear match_count and count_sat.
REQ-013 out  output  1  registered one-cycle match pulse.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 count_sat  output  1  high while match_count is at its all-ones value.
REQ-016 pat_q  output  PAT_W  currently active pattern.

Function
REQ-017 SHALL keep a PAT_W-bit history register and a fill counter (0..PAT_W) of valid consumed bits.
REQ-018 On each cycle with in_valid=1, SHALL shift in into the history LSB and increment fill, saturating at PAT_W.
REQ-019 SHALL flag a match when in_valid=1, fill >= PAT_W-1, and {history[PAT_W-2:0], in} == pat_q.
REQ-020 SHALL assert out for exactly one cycle, the cycle after the completing bit is sampled (latency 1); otherwise out=0.
REQ-021 With overlap=1, SHALL leave fill unchanged on a match, so the matching suffix is reused.
REQ-022 With overlap=0, SHALL set fill to 0 on a match, so the next match needs PAT_W fresh bits.
REQ-023 SHALL sample overlap in the cycle of the match; changing it mid-stream affects only later matches.
REQ-024 On pat_load=1, SHALL update pat_q to pat_data on the next edge and clear fill to 0.
REQ-025 When pat_load=1, SHALL discard that cycle's in_valid bit and suppress any match in that cycle.
REQ-026 On a match, SHALL increment match_count by 1, holding it at 2^CNT_W-1 once reached.
REQ-027 SHALL assert count_sat combinationally from match_count == all-ones.
REQ-028 On clr_count=1, SHALL set match_count to 0.
REQ-029 If clr_count and a match occur in the same cycle, SHALL set match_count to 1 and still pulse out.
REQ-030 When in_valid=0, SHALL hold history, fill and match_count and produce no match.

Reset
REQ-031 On rst=1, SHALL set history to 0, fill to 0, out to 0, match_count to 0 and pat_q to RST_PAT.
REQ-032 rst SHALL take priority over pat_load, clr_count and in_valid in the same cycle.
REQ-033 Mid-stream reset SHALL discard partial history; no match can fire until PAT_W new bits are consumed.

Verification
REQ-034 Bench SHALL drive, with defaults and overlap=1, in_valid=1 and stream 1,1,0,1,1,0,1 -> out pulses after bits 4 and 7; match_count=2.
REQ-035 Bench SHALL repeat the REQ-034 stream with overlap=0 -> a single pulse after bit 4; match_count=1.
REQ-036 Bench SHALL drive 1,1,0 with in_valid=1, then idle two cycles with in_valid=0, then 1 -> pulse one cycle after the final bit; no pulse during the idle cycles.
REQ-037 Bench SHALL pulse pat_load with pat_data=4'b0110 after bits 1,1,0, then drive 0,1,1,0 -> no match from the pre-load bits; pulse after the final 0; pat_q=0110.
REQ-038 Bench SHALL use CNT_W=2 and drive 5 overlapping 1101 matches -> match_count holds 3 with count_sat=1; clr_count coincident with the next match -> match_count=1.
REQ-039 Bench SHALL assert rst after 1,1,0, then drive 1 -> no pulse; all outputs are at reset values one cycle after rst.
